// File: rtl/fp_stream_checker.sv
// Stream-driven self-checking harness for the FP unit: issues vectors, compares in-order results.
// Optional first-failure capture ports are enabled with FP_CHECKER_FAIL_LOG_EN.
module fp_stream_checker #(
  parameter int XLEN    = 64,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_last,
  input  logic [XLEN-1:0]  vec_data1,
  input  logic [XLEN-1:0]  vec_data2,
  input  logic [XLEN-1:0]  vec_data3,
  input  logic [XLEN-1:0]  vec_result,
  input  logic [4:0]       vec_flags,
  input  logic [1:0]       vec_fmt,
  input  logic [2:0]       vec_rm,
  input  logic [1:0]       vec_op,
  input  logic [9:0]       vec_opcode,
  output logic             exe_enable,
  output logic [XLEN-1:0]  exe_data1,
  output logic [XLEN-1:0]  exe_data2,
  output logic [XLEN-1:0]  exe_data3,
  output logic [1:0]       exe_fmt,
  output logic [2:0]       exe_rm,
  output logic [1:0]       exe_op,
  output logic [9:0]       exe_opcode,
  input  logic [XLEN-1:0]  dut_result,
  input  logic [4:0]       dut_flags,
  input  logic             dut_ready,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             done,
  output logic             pass,
`ifdef FP_CHECKER_FAIL_LOG_EN
  output logic             fail_valid,
  output logic [CNT_W-1:0] fail_index,
  output logic [XLEN-1:0]  fail_expected,
  output logic [XLEN-1:0]  fail_calculated,
  output logic [4:0]       fail_flags_exp,
  output logic [4:0]       fail_flags_calc,
`endif
  output logic             err_timeout,
  output logic             err_spurious
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      flags;
    logic [1:0]      fmt;
    logic [9:0]      opcode;
  } exp_t;

  state_t          state_q, state_d;
  exp_t            fifo [MAX_OUT];
  exp_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wd_cnt;
  logic            full, empty, active, pop, spurious, hs, wd_fire;
  logic [63:0]     dr64, er64, mask, res_diff;
  logic            no_mask, fmt_bad, cmp_fail;
  logic [1:0]      fail_inc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign full     = (count == CW'(MAX_OUT));
  assign empty    = (count == '0);
  assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign pop      = dut_ready && !empty;
  assign spurious = dut_ready && empty;
  assign wd_fire  = active && !empty && !dut_ready && (wd_cnt == WW'(TIMEOUT - 1));
  // A retiring op frees its slot in the same cycle, so a full FIFO can still accept.
  assign vec_ready = (state_q == S_RUN) && (!full || pop) && !wd_fire;
  assign hs        = vec_valid && vec_ready;
  assign head      = fifo[rd_ptr];

  // Canonical-NaN results only need the quiet-NaN exponent/payload-MSB field to agree.
  always_comb begin
    dr64    = 64'(dut_result);
    er64    = 64'(head.result);
    no_mask = head.opcode[9] | head.opcode[6];
    mask    = '0;
    mask[XLEN-1:0] = '1;
    if (!no_mask && head.fmt == 2'd0 && dr64[31:0] == 32'h7FC0_0000)
      mask = 64'h0000_0000_7FC0_0000;
    else if (!no_mask && head.fmt == 2'd1 && dr64 == 64'h7FF8_0000_0000_0000)
      mask = 64'h7FF8_0000_0000_0000;
    res_diff = (dr64 ^ er64) & mask;
    fmt_bad  = (XLEN == 32) && (head.fmt == 2'd1);
    cmp_fail = (|res_diff) || (|(dut_flags ^ head.flags)) || fmt_bad;
    fail_inc = {1'b0, pop & cmp_fail} + {1'b0, spurious};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (wd_fire) state_d = S_DONE;
               else if (hs && vec_last) state_d = S_DRAIN;
      S_DRAIN: if (wd_fire || (empty && !exe_enable)) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  assign done = (state_q == S_DONE);
  assign pass = done && (fail_count == '0) && !err_timeout && !err_spurious;

  always_ff @(posedge clock) begin
    if (hs) fifo[wr_ptr] <= '{result: vec_result, flags: vec_flags, fmt: vec_fmt, opcode: vec_opcode};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wd_cnt       <= '0;
      exe_enable   <= 1'b0;
      exe_data1    <= '0;
      exe_data2    <= '0;
      exe_data3    <= '0;
      exe_fmt      <= '0;
      exe_rm       <= '0;
      exe_op       <= '0;
      exe_opcode   <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state_q    <= state_d;
      exe_enable <= hs;
      if (hs) begin
        exe_data1  <= vec_data1;
        exe_data2  <= vec_data2;
        exe_data3  <= vec_data3;
        exe_fmt    <= vec_fmt;
        exe_rm     <= vec_rm;
        exe_op     <= vec_op;
        exe_opcode <= vec_opcode;
      end
      if (wd_fire) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        err_timeout <= 1'b1;
      end else begin
        if (hs)  wr_ptr <= ptr_inc(wr_ptr);
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(hs) - CW'(pop);
      end
      wd_cnt <= (!active || empty || dut_ready) ? '0 : wd_cnt + 1'b1;
      if (pop && !cmp_fail) pass_count <= sat_add(pass_count, 2'd1);
      if (fail_inc != 2'd0) fail_count <= sat_add(fail_count, fail_inc);
      if (spurious) err_spurious <= 1'b1;
    end
  end

`ifdef FP_CHECKER_FAIL_LOG_EN
  logic [CNT_W-1:0] ret_idx;

  // Results retire in acceptance order, so the retire index is the vector index.
  always_ff @(posedge clock) begin
    if (reset) begin
      ret_idx         <= '0;
      fail_valid      <= 1'b0;
      fail_index      <= '0;
      fail_expected   <= '0;
      fail_calculated <= '0;
      fail_flags_exp  <= '0;
      fail_flags_calc <= '0;
    end else begin
      if (pop) ret_idx <= ret_idx + 1'b1;
      if (pop && cmp_fail && !fail_valid) begin
        fail_valid      <= 1'b1;
        fail_index      <= ret_idx;
        fail_expected   <= head.result;
        fail_calculated <= dut_result;
        fail_flags_exp  <= head.flags;
        fail_flags_calc <= dut_flags;
      end
    end
  end
`endif

endmodule
